// File: rtl/systolic_gemm_tile.sv
// Output-stationary systolic GEMM tile: RESULT = A(ROWS x K) * B(K x COLS) with internal operand skew,
// START/DONE run handshake, valid/ready operand streaming and an accumulate mode for K-tiling.
module systolic_gemm_tile #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ROWS      = 3,
  parameter int unsigned COLS      = 3,
  parameter int unsigned KMAX      = 16,
  parameter int unsigned ACC_WIDTH = 2 * WIDTH + $clog2(KMAX),
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                                     CLK,
  input  logic                                     SYNC_RST,
  input  logic                                     START,
  input  logic                                     ACC,
  input  logic [$clog2(KMAX+1)-1:0]                K_LEN,
  output logic                                     BUSY,
  input  logic                                     IN_VALID,
  output logic                                     IN_READY,
  input  logic [ROWS-1:0][WIDTH-1:0]               A_COL,
  input  logic [COLS-1:0][WIDTH-1:0]               B_ROW,
  output logic                                     DONE,
  output logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] RESULT
);

  localparam int unsigned KW = $clog2(KMAX + 1);
  localparam int unsigned DW = $clog2(ROWS + COLS);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  state_e                                   state_q, state_d;
  logic [KW-1:0]                            k_len_q, k_len_d;
  logic [KW-1:0]                            beat_q, beat_d;
  logic [DW-1:0]                            drain_q, drain_d;
  logic                                     busy_q, busy_d;
  logic                                     ready_q, ready_d;
  logic                                     done_q, done_d;
  logic                                     clear_c, accept_c;
  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]     a_pe_c, b_pe_c;

  function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    logic [PW-1:0] ax, bx, p;
    if (SIGNED) begin
      ax = PW'($signed(a));
      bx = PW'($signed(b));
    end else begin
      ax = PW'(a);
      bx = PW'(b);
    end
    p = ax * bx;
    if (SIGNED) return ACC_WIDTH'($signed(p));
    return ACC_WIDTH'(p);
  endfunction

  // Run control: IDLE -> LOAD (K_LEN beats) -> DRAIN (ROWS+COLS-1 cycles) -> IDLE with DONE
  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    beat_d   = beat_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    clear_c  = 1'b0;
    accept_c = (state_q == LOAD) && IN_VALID && ready_q;
    unique case (state_q)
      IDLE: begin
        if (START && (K_LEN != '0) && (K_LEN <= KW'(KMAX))) begin
          state_d = LOAD;
          k_len_d = K_LEN;
          beat_d  = '0;
          clear_c = !ACC;
        end
      end
      LOAD: begin
        if (accept_c) begin
          beat_d = beat_q + KW'(1);
          if (beat_d == k_len_q) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DW'(ROWS + COLS - 2)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == LOAD);
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state_q <= IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
    end
  end

  // Row i chain: i skew stages followed by the PE-to-PE rightward forward registers
  for (genvar i = 0; i < ROWS; i++) begin : g_row_chain
    logic [i+COLS-1:0][WIDTH-1:0] chain_q, chain_d;
    always_comb begin
      chain_d = chain_q;
      if (busy_q) begin
        chain_d    = chain_q << WIDTH;
        chain_d[0] = accept_c ? A_COL[i] : '0;
      end
    end
    always_ff @(posedge CLK) begin
      if (SYNC_RST) chain_q <= '0;
      else          chain_q <= chain_d;
    end
    for (genvar j = 0; j < COLS; j++) begin : g_tap
      assign a_pe_c[i][j] = chain_q[i+j];
    end
  end

  // Column j chain: j skew stages followed by the PE-to-PE downward forward registers
  for (genvar j = 0; j < COLS; j++) begin : g_col_chain
    logic [j+ROWS-1:0][WIDTH-1:0] chain_q, chain_d;
    always_comb begin
      chain_d = chain_q;
      if (busy_q) begin
        chain_d    = chain_q << WIDTH;
        chain_d[0] = accept_c ? B_ROW[j] : '0;
      end
    end
    always_ff @(posedge CLK) begin
      if (SYNC_RST) chain_q <= '0;
      else          chain_q <= chain_d;
    end
    for (genvar i = 0; i < ROWS; i++) begin : g_tap
      assign b_pe_c[i][j] = chain_q[i+j];
    end
  end

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if (clear_c)     acc_d[i][j] = '0;
        else if (busy_q) acc_d[i][j] = acc_q[i][j] + mac_term(a_pe_c[i][j], b_pe_c[i][j]);
      end
    end
  end

  assign BUSY     = busy_q;
  assign IN_READY = ready_q;
  assign DONE     = done_q;
  assign RESULT   = acc_q;

endmodule

// File: tb/tb_systolic_gemm_tile.sv
// Scoreboard bench for systolic_gemm_tile: unsigned and signed instances share stimulus;
// expected results are queued at START and popped by a monitor on DONE.
module tb_systolic_gemm_tile;

  localparam int unsigned W  = 8;
  localparam int unsigned R  = 3;
  localparam int unsigned C  = 3;
  localparam int unsigned KM = 16;
  localparam int unsigned AW = 20;
  localparam int unsigned KW = 5;
  localparam int unsigned RW = R * C * AW;

  typedef logic [R-1:0][C-1:0][AW-1:0] res_t;
  typedef struct {
    string name;
    res_t  exp_u;
    res_t  exp_s;
  } exp_t;

  logic            clk = 1'b0;
  logic            sync_rst, start, acc, in_valid;
  logic [KW-1:0]   k_len;
  logic [R-1:0][W-1:0] a_col;
  logic [C-1:0][W-1:0] b_row;
  logic            u_busy, u_ready, u_done, s_busy, s_ready, s_done;
  res_t            u_res, s_res;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   edges = 0;
  int   last_acc = 0;

  int base_a [R][C] = '{'{4, 3, 7}, '{4, 4, 7}, '{6, 8, 2}};
  int base_b [R][C] = '{'{9, 4, 5}, '{10, 4, 5}, '{7, 4, 7}};
  int base_r [R][C] = '{'{115, 56, 84}, '{125, 60, 89}, '{148, 64, 84}};
  int accm_r [R][C] = '{'{230, 112, 168}, '{250, 120, 178}, '{296, 128, 168}};
  logic [W-1:0] a_m [R][KM];
  logic [W-1:0] b_m [KM][C];

  systolic_gemm_tile #(.WIDTH(W), .ROWS(R), .COLS(C), .KMAX(KM), .ACC_WIDTH(AW), .SIGNED(1'b0)) dut_u (
    .CLK(clk), .SYNC_RST(sync_rst), .START(start), .ACC(acc), .K_LEN(k_len), .BUSY(u_busy),
    .IN_VALID(in_valid), .IN_READY(u_ready), .A_COL(a_col), .B_ROW(b_row), .DONE(u_done), .RESULT(u_res)
  );

  systolic_gemm_tile #(.WIDTH(W), .ROWS(R), .COLS(C), .KMAX(KM), .ACC_WIDTH(AW), .SIGNED(1'b1)) dut_s (
    .CLK(clk), .SYNC_RST(sync_rst), .START(start), .ACC(acc), .K_LEN(k_len), .BUSY(s_busy),
    .IN_VALID(in_valid), .IN_READY(s_ready), .A_COL(a_col), .B_ROW(b_row), .DONE(s_done), .RESULT(s_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  function automatic res_t mk(input int v [R][C]);
    res_t r;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) r[i][j] = AW'(v[i][j]);
    return r;
  endfunction

  function automatic res_t mk_all(input logic [AW-1:0] v);
    res_t r;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) r[i][j] = v;
    return r;
  endfunction

  task automatic fill_base();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < 3; k++) a_m[i][k] = W'(base_a[i][k]);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < C; j++) b_m[k][j] = W'(base_b[k][j]);
  endtask

  task automatic fill_const(input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int k = 0; k < KM; k++) begin
      for (int i = 0; i < R; i++) a_m[i][k] = av;
      for (int j = 0; j < C; j++) b_m[k][j] = bv;
    end
  endtask

  // Issue one run; the expected result is queued only for runs meant to complete
  task automatic drive_run(input string nm, input int k, input bit acc_in, input bit bubbles,
                           input int stop_at, input bit mid_start, input res_t eu, input res_t es);
    int   b;
    int   t;
    exp_t e;
    if (stop_at == k) begin
      e.name  = nm;
      e.exp_u = eu;
      e.exp_s = es;
      sb_q.push_back(e);
    end
    start = 1'b1;
    acc   = acc_in;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    b = 0;
    t = 0;
    while (b < stop_at && t < 100) begin
      if (mid_start && t == 1) begin
        start = 1'b1;
        acc   = 1'b0;
        k_len = KW'(1);
      end else begin
        start = 1'b0;
      end
      if (bubbles && (t % 2 == 1)) begin
        in_valid = 1'b0;
        a_col    = {R{8'hAA}};
        b_row    = {C{8'h55}};
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < R; i++) a_col[i] = a_m[i][b];
        for (int j = 0; j < C; j++) b_row[j] = b_m[b][j];
      end
      if (in_valid && u_ready) b++;
      t++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({"beats_", nm}, RW'(b), RW'(stop_at));
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (!u_done && t < 60) begin
      @(negedge clk);
      #2;
      t++;
    end
    check({"done_seen_", nm}, RW'(u_done), RW'(1));
  endtask

  // Monitor: note accepts, and on DONE pop the scoreboard and compare
  always @(negedge clk) begin
    #1;
    if (in_valid && u_ready) last_acc = edges + 1;
    if (u_done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got DONE=1 at edge %0d, expected no pending run", edges);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_result_u"}, RW'(u_res), RW'(mon_e.exp_u));
        check({mon_e.name, "_result_s"}, RW'(s_res), RW'(mon_e.exp_s));
        check({mon_e.name, "_done_latency"}, RW'(edges - last_acc), RW'(5));
        check({mon_e.name, "_done_s"}, RW'(s_done), RW'(1));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish by %0t, expected end of test", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sync_rst = 1'b1;
    start    = 1'b0;
    acc      = 1'b0;
    in_valid = 1'b0;
    k_len    = '0;
    a_col    = '0;
    b_row    = '0;
    repeat (2) @(negedge clk);
    sync_rst = 1'b0;
    #2;
    check("rst_busy", RW'(u_busy), RW'(0));
    check("rst_ready", RW'(u_ready), RW'(0));
    check("rst_done", RW'(u_done), RW'(0));
    check("rst_result", RW'(u_res), RW'(0));

    fill_base();
    @(negedge clk);
    drive_run("base", 3, 1'b0, 1'b0, 3, 1'b0, mk(base_r), mk(base_r));
    wait_done("base");
    drive_run("accum", 3, 1'b1, 1'b0, 3, 1'b0, mk(accm_r), mk(accm_r));
    wait_done("accum");
    @(negedge clk);
    drive_run("bubble", 3, 1'b0, 1'b1, 3, 1'b0, mk(base_r), mk(base_r));
    wait_done("bubble");

    fill_const(8'hFF, 8'd2);
    @(negedge clk);
    drive_run("sign", 4, 1'b0, 1'b0, 4, 1'b0, mk_all(20'd2040), mk_all(20'hFFFF8));
    wait_done("sign");

    fill_const(8'hFF, 8'hFF);
    @(negedge clk);
    drive_run("fullk", 16, 1'b0, 1'b0, 16, 1'b0, mk_all(20'hFE010), mk_all(20'd16));
    wait_done("fullk");

    fill_base();
    @(negedge clk);
    drive_run("abort", 3, 1'b0, 1'b0, 2, 1'b0, '0, '0);
    sync_rst = 1'b1;
    @(negedge clk);
    sync_rst = 1'b0;
    #1;
    check("abort_busy", RW'(u_busy), RW'(0));
    check("abort_ready", RW'(u_ready), RW'(0));
    check("abort_result", RW'(u_res), RW'(0));

    @(negedge clk);
    start = 1'b1;
    k_len = KW'(0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("klen0_busy", RW'(u_busy), RW'(0));
    check("klen0_ready", RW'(u_ready), RW'(0));
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(17);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("klen17_busy", RW'(u_busy), RW'(0));

    @(negedge clk);
    drive_run("rerun", 3, 1'b0, 1'b0, 3, 1'b1, mk(base_r), mk(base_r));
    wait_done("rerun");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", RW'(sb_q.size()), RW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
